// File: rtl/branch_resolve_unit.sv
// Branch resolution for the EX stage.
//
// Decides taken/not-taken from the branch_comp flags and funct3, compares the
// result with the fetch-stage prediction, and on a mispredict sends one
// registered redirect to fetch over a valid/ready handshake. IF/ID is then
// flushed for FLUSH_CYCLES more cycles. Saturating counters record accepted
// branches and mispredicts.
//
// Ports:
//   Clk, Reset_N          clock, asynchronous active-low reset
//   Br_Valid/Br_Jump      EX holds a branch / an unconditional jump
//   Br_Funct3             B-type funct3
//   Branch_Equal/Lt       comparison flags from branch_comp
//   Branch_Un_Ctrl        unsigned-compare select back to branch_comp
//   Pred_Taken            prediction made in fetch
//   Br_Pc/Br_Target       branch PC and computed taken target
//   Redirect_*            corrected-PC handshake towards fetch
//   Flush/Stall_Ex        kill IF/ID, hold EX while a redirect is in flight
//   Illegal_Br            one-cycle pulse for reserved funct3 010/011
//   Branch_Count          accepted branches/jumps (saturating)
//   Mispredict_Count      accepted mispredicts (saturating)
module branch_resolve_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset_N,
  input  logic             Br_Valid,
  input  logic             Br_Jump,
  input  logic [2:0]       Br_Funct3,
  input  logic             Branch_Equal,
  input  logic             Branch_Lt,
  input  logic             Pred_Taken,
  input  logic [XLEN-1:0]  Br_Pc,
  input  logic [XLEN-1:0]  Br_Target,
  output logic             Branch_Un_Ctrl,
  output logic             Redirect_Valid,
  input  logic             Redirect_Ready,
  output logic [XLEN-1:0]  Redirect_Pc,
  output logic             Flush,
  output logic             Stall_Ex,
  output logic             Illegal_Br,
  output logic [CNT_W-1:0] Branch_Count,
  output logic [CNT_W-1:0] Mispredict_Count
);

  typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_e;

  // Down-counter reload; FLUSH_CYCLES=0 never enters StFlush so the value is unused there.
  localparam logic [3:0]       FlushLoad = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;
  localparam logic [CNT_W-1:0] CntMax    = '1;

  state_e           state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic             accept;
  logic             cond_taken;
  logic             illegal_f3;
  logic             taken;
  logic             mispredict;
  logic [XLEN-1:0]  correct_pc;

  // Unsigned compare for BLTU/BGEU only.
  assign Branch_Un_Ctrl = (Br_Funct3[2:1] == 2'b11);

  always_comb begin
    cond_taken = 1'b0;
    illegal_f3 = 1'b0;
    case (Br_Funct3)
      3'b000:         cond_taken = Branch_Equal;
      3'b001:         cond_taken = ~Branch_Equal;
      3'b100, 3'b110: cond_taken = Branch_Lt;
      3'b101, 3'b111: cond_taken = ~Branch_Lt;
      default:        illegal_f3 = 1'b1;
    endcase
  end

  assign accept     = Br_Valid && (state_q == StIdle);
  assign taken      = Br_Jump | cond_taken;
  assign mispredict = taken ^ Pred_Taken;
  // Fall-through wraps modulo 2^XLEN.
  assign correct_pc = taken ? Br_Target : (Br_Pc + XLEN'(4));

  // State register.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q       <= StIdle;
      flush_cnt_q   <= 4'd0;
      redirect_pc_q <= '0;
      illegal_q     <= 1'b0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      redirect_pc_q <= redirect_pc_d;
      illegal_q     <= illegal_d;
      br_cnt_q      <= br_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    redirect_pc_d = redirect_pc_q;
    unique case (state_q)
      StIdle: begin
        if (accept && mispredict) begin
          redirect_pc_d = correct_pc;
          state_d       = StRedirect;
        end
      end
      StRedirect: begin
        if (Redirect_Ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d     = StFlush;
            flush_cnt_d = FlushLoad;
          end
        end
      end
      StFlush: begin
        if (flush_cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Counters and illegal pulse.
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    illegal_d = accept && !Br_Jump && illegal_f3;
    if (accept && (br_cnt_q != CntMax)) begin
      br_cnt_d = br_cnt_q + 1'b1;
    end
    if (accept && mispredict && (mis_cnt_q != CntMax)) begin
      mis_cnt_d = mis_cnt_q + 1'b1;
    end
  end

  // Outputs, all decoded from registered state.
  always_comb begin
    Redirect_Valid   = (state_q == StRedirect);
    Flush            = (state_q != StIdle);
    Stall_Ex         = (state_q != StIdle);
    Redirect_Pc      = redirect_pc_q;
    Illegal_Br       = illegal_q;
    Branch_Count     = br_cnt_q;
    Mispredict_Count = mis_cnt_q;
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned FLUSH_CYCLES = 2;

  logic            Clk = 1'b0;
  logic            Reset_N = 1'b1;
  logic            Br_Valid = 1'b0;
  logic            Br_Jump = 1'b0;
  logic [2:0]      Br_Funct3 = 3'd0;
  logic            Branch_Equal = 1'b0;
  logic            Branch_Lt = 1'b0;
  logic            Pred_Taken = 1'b0;
  logic [XLEN-1:0] Br_Pc = '0;
  logic [XLEN-1:0] Br_Target = '0;
  logic            Redirect_Ready = 1'b0;

  logic            Branch_Un_Ctrl, Redirect_Valid, Flush, Stall_Ex, Illegal_Br;
  logic [XLEN-1:0] Redirect_Pc;
  logic [15:0]     Branch_Count, Mispredict_Count;

  logic            s4_un_ctrl, s4_redirect_valid, s4_flush, s4_stall_ex, s4_illegal_br;
  logic [XLEN-1:0] s4_redirect_pc;
  logic [3:0]      s4_branch_count, s4_mispredict_count;

  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(16)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .Br_Valid(Br_Valid), .Br_Jump(Br_Jump),
    .Br_Funct3(Br_Funct3), .Branch_Equal(Branch_Equal), .Branch_Lt(Branch_Lt),
    .Pred_Taken(Pred_Taken), .Br_Pc(Br_Pc), .Br_Target(Br_Target),
    .Branch_Un_Ctrl(Branch_Un_Ctrl), .Redirect_Valid(Redirect_Valid),
    .Redirect_Ready(Redirect_Ready), .Redirect_Pc(Redirect_Pc), .Flush(Flush),
    .Stall_Ex(Stall_Ex), .Illegal_Br(Illegal_Br), .Branch_Count(Branch_Count),
    .Mispredict_Count(Mispredict_Count)
  );

  // Narrow-counter copy used only for saturation checks.
  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(4)) dut_sat (
    .Clk(Clk), .Reset_N(Reset_N), .Br_Valid(Br_Valid), .Br_Jump(Br_Jump),
    .Br_Funct3(Br_Funct3), .Branch_Equal(Branch_Equal), .Branch_Lt(Branch_Lt),
    .Pred_Taken(Pred_Taken), .Br_Pc(Br_Pc), .Br_Target(Br_Target),
    .Branch_Un_Ctrl(s4_un_ctrl), .Redirect_Valid(s4_redirect_valid),
    .Redirect_Ready(Redirect_Ready), .Redirect_Pc(s4_redirect_pc), .Flush(s4_flush),
    .Stall_Ex(s4_stall_ex), .Illegal_Br(s4_illegal_br), .Branch_Count(s4_branch_count),
    .Mispredict_Count(s4_mispredict_count)
  );

  initial forever #5 Clk = ~Clk;

  typedef struct packed {
    logic ill;
    logic mis;
  } acc_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] redir_q[$];
  acc_t        acc_q[$];
  acc_t        mon_acc;
  int unsigned exp_br = 0;
  int unsigned exp_mis = 0;
  int unsigned flush_left = 0;
  logic        exp_un = 1'b0;
  int unsigned rdy_mode = 0;  // 0 random, 1 always ready, 2 never ready

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [31:0] sat(input int unsigned n, input int unsigned w);
    int unsigned mx;
    mx = (32'd1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // Reference: branch outcome from the operands and the instruction meaning.
  function automatic logic model_taken(input logic jump, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b);
    if (jump) return 1'b1;
    case (f3)
      3'd0:    return a == b;                     // BEQ
      3'd1:    return a != b;                     // BNE
      3'd4:    return $signed(a) < $signed(b);    // BLT
      3'd5:    return $signed(a) >= $signed(b);   // BGE
      3'd6:    return a < b;                      // BLTU
      3'd7:    return a >= b;                     // BGEU
      default: return 1'b0;                       // reserved
    endcase
  endfunction

  task automatic issue(input logic jump, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic pred, input logic [31:0] pc,
                       input logic [31:0] tgt);
    int unsigned budget;
    logic        un, taken, mis;
    acc_t        ac;
    budget = 0;
    @(negedge Clk);
    while (Stall_Ex && budget < 200) begin
      @(negedge Clk);
      budget++;
    end
    if (budget >= 200) timeout("wait_idle");
    @(posedge Clk);
    #1;
    un           = (f3 == 3'd6) || (f3 == 3'd7);
    exp_un       = un;
    Br_Valid     = 1'b1;
    Br_Jump      = jump;
    Br_Funct3    = f3;
    Branch_Equal = (a == b);
    Branch_Lt    = un ? (a < b) : ($signed(a) < $signed(b));
    Pred_Taken   = pred;
    Br_Pc        = pc;
    Br_Target    = tgt;
    taken        = model_taken(jump, f3, a, b);
    mis          = taken != pred;
    @(posedge Clk);
    exp_br++;
    if (mis) begin
      exp_mis++;
      redir_q.push_back(taken ? tgt : pc + 32'd4);
    end
    ac.ill = !jump && ((f3 == 3'd2) || (f3 == 3'd3));
    ac.mis = mis;
    acc_q.push_back(ac);
    #1 Br_Valid = 1'b0;
  endtask

  // Redirect_Ready driver.
  initial forever begin
    @(posedge Clk);
    #1;
    case (rdy_mode)
      0:       Redirect_Ready = 1'($urandom_range(0, 1));
      1:       Redirect_Ready = 1'b1;
      default: Redirect_Ready = 1'b0;
    endcase
  end

  // Monitor / scoreboard.
  always @(negedge Clk) begin
    if (!Reset_N) begin
      flush_left = 0;
    end else begin
      if (Br_Valid) check("branch_un_ctrl", Branch_Un_Ctrl, exp_un);
      if (redir_q.size() > 0) begin
        check("redirect_valid", Redirect_Valid, 1);
        check("redirect_pc", Redirect_Pc, redir_q[0]);
        check("flush_in_redirect", Flush, 1);
        check("stall_in_redirect", Stall_Ex, 1);
        if (Redirect_Valid && Redirect_Ready) begin
          void'(redir_q.pop_front());
          flush_left = FLUSH_CYCLES;
        end
      end else begin
        check("redirect_valid_idle", Redirect_Valid, 0);
        check("flush", Flush, flush_left > 0);
        check("stall_ex", Stall_Ex, flush_left > 0);
        if (flush_left > 0) flush_left--;
      end
      if (acc_q.size() > 0) begin
        mon_acc = acc_q.pop_front();
        check("illegal_br", Illegal_Br, mon_acc.ill);
        check("redirect_latency", Redirect_Valid, mon_acc.mis);
      end else begin
        check("illegal_br_idle", Illegal_Br, 0);
      end
      check("branch_count", Branch_Count, sat(exp_br, 16));
      check("mispredict_count", Mispredict_Count, sat(exp_mis, 16));
      check("branch_count_w4", s4_branch_count, sat(exp_br, 4));
      check("mispredict_count_w4", s4_mispredict_count, sat(exp_mis, 4));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_redirect_valid"}, Redirect_Valid, 0);
    check({tag, "_redirect_pc"}, Redirect_Pc, 0);
    check({tag, "_flush"}, Flush, 0);
    check({tag, "_stall_ex"}, Stall_Ex, 0);
    check({tag, "_illegal_br"}, Illegal_Br, 0);
    check({tag, "_branch_count"}, Branch_Count, 0);
    check({tag, "_mispredict_count"}, Mispredict_Count, 0);
    check({tag, "_branch_count_w4"}, s4_branch_count, 0);
  endtask

  initial begin
    int unsigned budget;
    logic [31:0] a, b, pc;

    // Power-on reset.
    #1 Reset_N = 1'b0;
    #2 check_all_zero("reset");
    #19 Reset_N = 1'b1;
    rdy_mode = 1;

    // BEQ taken, predicted not-taken: redirect to target, 3 flush cycles.
    issue(1'b0, 3'd0, 32'd5, 32'd5, 1'b0, 32'h100, 32'h80);
    // BLTU taken, predicted taken: no redirect.
    issue(1'b0, 3'd6, 32'd1, 32'd2, 1'b1, 32'h200, 32'h300);
    repeat (6) @(negedge Clk);
    check("beq_bltu_branch_count", Branch_Count, 2);
    check("beq_bltu_mispredict_count", Mispredict_Count, 1);

    // BGE taken, predicted not-taken, fetch stalls the redirect.
    rdy_mode = 2;
    repeat (2) @(posedge Clk);
    issue(1'b0, 3'd5, 32'd3, 32'd1, 1'b0, 32'hFFFF_FFFC, 32'h40);
    #1;
    Br_Valid  = 1'b1;  // ignored while EX is stalled
    Br_Funct3 = 3'd0;
    exp_un    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("bp_redirect_valid", Redirect_Valid, 1);
      check("bp_redirect_pc", Redirect_Pc, 32'h40);
      check("bp_stall_ex", Stall_Ex, 1);
    end
    Br_Valid = 1'b0;
    rdy_mode = 1;
    repeat (6) @(negedge Clk);
    check("bp_branch_count", Branch_Count, 3);

    // BNE not taken, predicted taken at the top of memory: fall-through wraps.
    issue(1'b0, 3'd1, 32'd9, 32'd9, 1'b1, 32'hFFFF_FFFC, 32'h1234);
    // Reserved funct3: never taken, pulse Illegal_Br.
    issue(1'b0, 3'd2, 32'd1, 32'd2, 1'b1, 32'h400, 32'h800);
    issue(1'b0, 3'd3, 32'd1, 32'd2, 1'b0, 32'h500, 32'h900);

    // Reset while flushing.
    issue(1'b1, 3'd2, 32'd0, 32'd0, 1'b0, 32'h600, 32'h700);
    @(posedge Clk);
    #3 Reset_N = 1'b0;
    #1 check_all_zero("midflush_reset");
    redir_q.delete();
    acc_q.delete();
    exp_br  = 0;
    exp_mis = 0;
    repeat (2) @(posedge Clk);
    #2 Reset_N = 1'b1;

    // 20 mispredicting jumps: the 4-bit counters stick at 15.
    for (int i = 0; i < 20; i++) begin
      issue(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0, 32'h1000 + 32'(i * 4),
            32'h2000 + 32'(i * 8));
    end
    repeat (6) @(negedge Clk);
    check("sat_branch_count_w4", s4_branch_count, 15);
    check("sat_mispredict_count_w4", s4_mispredict_count, 15);
    check("sat_branch_count", Branch_Count, 20);
    check("sat_mispredict_count", Mispredict_Count, 20);

    // Randomized traffic with random fetch backpressure.
    rdy_mode = 0;
    for (int i = 0; i < 80; i++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      issue(($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)), a, b,
            1'($urandom_range(0, 1)), pc, $urandom & 32'hFFFF_FFFE);
    end

    budget = 0;
    while ((redir_q.size() > 0 || Stall_Ex) && budget < 200) begin
      @(negedge Clk);
      budget++;
    end
    if (budget >= 200) timeout("drain");
    repeat (3) @(negedge Clk);
    check("redirects_drained", redir_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumes Branch_Equal/Branch_Lt from branch_comp in EX.
- Drives Branch_Un_Ctrl back to branch_comp from funct3.
- Decides taken/not-taken against the fetch-stage static prediction.
- On mispredict, issues a registered PC redirect to fetch over a valid/ready handshake, then flushes IF/ID for a fixed number of cycles.
- Keeps saturating branch and mispredict counters for performance debug.

Parameters:
- XLEN, 32, data/PC width
- FLUSH_CYCLES, 2, cycles Flush stays asserted after redirect handshake; range 0..15
- CNT_W, 16, width of performance counters

Ports:
- Clk  input  1  rising-edge clock
- Reset_N  input  1  asynchronous active-low reset
- Br_Valid  input  1  EX holds a branch/jump this cycle
- Br_Jump  input  1  unconditional (JAL/JALR); funct3 ignored
- Br_Funct3  input  3  B-type funct3
- Branch_Equal  input  1  from branch_comp
- Branch_Lt  input  1  from branch_comp
- Pred_Taken  input  1  prediction made in fetch
- Br_Pc  input  XLEN  PC of branch instruction
- Br_Target  input  XLEN  computed taken target
- Branch_Un_Ctrl  output  1  to branch_comp: 1 for funct3 110/111, else 0 (combinational)
- Redirect_Valid  output  1  redirect request to fetch
- Redirect_Ready  input  1  fetch accepts redirect
- Redirect_Pc  output  XLEN  corrected PC
- Flush  output  1  kill IF/ID contents
- Stall_Ex  output  1  hold EX; new branches not accepted
- Illegal_Br  output  1  one-cycle pulse: funct3 010/011 with Br_Jump=0
- Branch_Count  output  CNT_W  accepted branches/jumps
- Mispredict_Count  output  CNT_W  mispredicts

Behaviour:
- Reset (async, Reset_N=0): state IDLE; Redirect_Valid=0, Redirect_Pc=0, Flush=0, Stall_Ex=0, Illegal_Br=0, both counters 0. Branch_Un_Ctrl depends only on Br_Funct3.
- Taken decode (Br_Jump=0):
  - 000 Equal; 001 !Equal
  - 100/110 Lt; 101/111 !Lt
  - 010/011 not taken, with Illegal_Br pulsed next cycle
- Br_Jump=1: always taken.
- Mispredict = taken XOR Pred_Taken. Correct PC = taken ? Br_Target : Br_Pc+4, computed modulo 2^XLEN so 0xFFFFFFFC+4 wraps to 0.
- Branch is accepted only when Br_Valid=1 in IDLE. Br_Valid in any other state is ignored, and the producer holds it under Stall_Ex.
- FSM:
  - IDLE: on accepted mispredict, register Redirect_Pc, set Redirect_Valid=1, go REDIRECT. A correct prediction stays in IDLE with no outputs beyond the counter update.
  - REDIRECT: Redirect_Valid=1, Flush=1, Stall_Ex=1; Redirect_Pc stable. On Redirect_Ready=1, drop Redirect_Valid next cycle. Then go FLUSH with down-counter=FLUSH_CYCLES-1, or go IDLE if FLUSH_CYCLES=0.
  - FLUSH: Flush=1, Stall_Ex=1. Decrement each cycle; at 0 go IDLE.
- Latency: Redirect_Valid rises the cycle after the accepting edge. Redirect_Ready already high gives a one-cycle REDIRECT.
- Flush high-time = REDIRECT cycles + FLUSH_CYCLES.
- Counters: Branch_Count +1 per accepted branch. Mispredict_Count +1 per accepted mispredict. Both saturate at 2^CNT_W-1 and never wrap.
- Reset mid-REDIRECT/FLUSH aborts immediately to IDLE and clears all outputs.
- Redirect_Ready while Redirect_Valid=0 is ignored.

Test Plan:
- BEQ predict-not-taken: Funct3=000, Equal=1, Pred_Taken=0, Br_Pc=0x100, Target=0x80, Ready=1. Expect:
  - Redirect_Valid=1 with Redirect_Pc=0x80 for exactly 1 cycle.
  - Flush=1 for 3 cycles, then IDLE.
  - Mispredict_Count=1, Branch_Count=1.
- BLTU correct prediction: Funct3=110, Lt=1, Pred_Taken=1. Expect:
  - Branch_Un_Ctrl=1.
  - No Redirect_Valid/Flush; Branch_Count increments, Mispredict_Count unchanged.
- Backpressure: BGE mispredict (Lt=0, Pred_Taken=0), Br_Pc=0xFFFFFFFC, Target=0x40; Redirect_Ready low 4 cycles. Expect:
  - Redirect_Valid and Redirect_Pc=0x40 held stable for 4 cycles.
  - Stall_Ex=1 throughout; a second Br_Valid meanwhile leaves Branch_Count unchanged.
- Wrap: BNE not taken (Equal=1) with Pred_Taken=1 at Br_Pc=0xFFFFFFFC. Expect Redirect_Pc=0x00000000.
- Illegal funct3=010 with Br_Valid=1. Expect Illegal_Br one-cycle pulse, not taken; mispredict only if Pred_Taken=1.
- Reset and saturation:
  - Reset_N low mid-FLUSH: all outputs 0 asynchronously, IDLE on release.
  - CNT_W=4 with 20 mispredicts: both counters stick at 15.
